// File: rtl/dynode_energy_int.sv
// dynode_energy_int
// Baseline-corrected energy integrator for one dynode channel. On the rising
// edge of dyn_event it latches the 8.8 baseline and the window length, sums
// (sample*256 - baseline) over the window, then publishes a clamped energy
// word (LSB = 1/4 ADC count) with a one-cycle valid strobe, a pileup flag and
// a saturating event counter.
//
// Build option: define DYN_EINT_PUABORT_EN to abort an event on any pileup
// seen during integration (no strobe, outputs untouched).
module dynode_energy_int #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            dyn_event,
    input  logic            dyn_pileup,
    input  logic [7:0]      dyn_adcdly,
    input  logic [15:0]     dyn_curval,
    input  logic [5:0]      intlen,
    output logic [15:0]     dyn_energy,
    output logic            dyn_energy_valid,
    output logic            dyn_energy_pu,
    output logic            dyn_busy,
    output logic [CNTW-1:0] dyn_evcnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INTEG = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]         state;
    logic               event_d;
    logic               event_rise;
    logic signed [23:0] acc;
    logic [6:0]         cnt;
    logic [15:0]        bl;
    logic               pu;
    logic signed [16:0] diff;
    logic signed [23:0] diff_ext;

    // Negative totals clamp to zero; the positive range never exceeds 22 bits,
    // so bits [21:6] give the quarter-LSB energy directly.
    function automatic logic [15:0] clamp_energy(input logic signed [23:0] a);
        return a[23] ? 16'h0000 : a[21:6];
    endfunction

    // Event counter sticks at all-ones rather than wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    assign event_rise = dyn_event & ~event_d;
    assign dyn_busy   = (state != S_IDLE);

    // Per-sample baseline-corrected contribution, sign-extended to the accumulator.
    always_comb begin
        diff     = $signed({1'b0, dyn_adcdly, 8'h00}) - $signed({1'b0, bl});
        diff_ext = {{7{diff[16]}}, diff};
    end

    // Control FSM, accumulator and published result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            event_d          <= 1'b0;
            acc              <= '0;
            cnt              <= '0;
            bl               <= '0;
            pu               <= 1'b0;
            dyn_energy       <= '0;
            dyn_energy_valid <= 1'b0;
            dyn_energy_pu    <= 1'b0;
            dyn_evcnt        <= '0;
        end else begin
            event_d          <= dyn_event;
            dyn_energy_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (event_rise) begin
                        bl    <= dyn_curval;
                        cnt   <= (intlen == 6'd0) ? 7'd64 : {1'b0, intlen};
                        acc   <= '0;
                        pu    <= 1'b0;
                        state <= S_INTEG;
                    end
                end
                S_INTEG: begin
                    acc <= acc + diff_ext;
                    cnt <= cnt - 7'd1;
                    pu  <= pu | dyn_pileup;
`ifdef DYN_EINT_PUABORT_EN
                    if (dyn_pileup)
                        state <= S_HOLD;
                    else if (cnt == 7'd1)
                        state <= S_DONE;
`else
                    if (cnt == 7'd1)
                        state <= S_DONE;
`endif
                end
                S_DONE: begin
                    // With pileup abort enabled, pu is necessarily clear here.
                    dyn_energy       <= clamp_energy(acc);
                    dyn_energy_pu    <= pu;
                    dyn_energy_valid <= 1'b1;
                    dyn_evcnt        <= sat_inc(dyn_evcnt);
                    state            <= S_HOLD;
                end
                S_HOLD: begin
                    if (!dyn_event)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dynode_energy_int.sv
// Directed testbench for dynode_energy_int. Counter width is reduced to 2 bits
// so evcnt saturation is reached within a handful of events.
module tb_dynode_energy_int;

    localparam int CNTW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            dyn_event;
    logic            dyn_pileup;
    logic [7:0]      dyn_adcdly;
    logic [15:0]     dyn_curval;
    logic [5:0]      intlen;
    logic [15:0]     dyn_energy;
    logic            dyn_energy_valid;
    logic            dyn_energy_pu;
    logic            dyn_busy;
    logic [CNTW-1:0] dyn_evcnt;

    int n_checks = 0;
    int n_errors = 0;

    dynode_energy_int #(.CNTW(CNTW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .dyn_event        (dyn_event),
        .dyn_pileup       (dyn_pileup),
        .dyn_adcdly       (dyn_adcdly),
        .dyn_curval       (dyn_curval),
        .intlen           (intlen),
        .dyn_energy       (dyn_energy),
        .dyn_energy_valid (dyn_energy_valid),
        .dyn_energy_pu    (dyn_energy_pu),
        .dyn_busy         (dyn_busy),
        .dyn_evcnt        (dyn_evcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one event, watch 80 edges for strobes, then release dyn_event.
    task automatic run_event(input logic [15:0] curval, input logic [5:0] len,
                             input logic [7:0] adc_idle, input logic [7:0] adc,
                             input int pu_k, input bit glitch,
                             output int strobes, output int strobe_at,
                             output logic [15:0] energy, output logic pu_o,
                             output logic busy_hold, output logic busy_end);
        strobes   = 0;
        strobe_at = -1;
        energy    = '0;
        pu_o      = 1'b0;
        dyn_adcdly = adc_idle;
        dyn_curval = curval;
        intlen     = len;
        dyn_event  = 1'b1;
        tick();                        // edge T
        dyn_adcdly = adc;
        dyn_curval = 16'hFFFF;         // later changes must not affect the event
        intlen     = 6'd1;
        for (int k = 1; k <= 80; k++) begin
            dyn_pileup = (k == pu_k);
            if (glitch && k == 3) dyn_event = 1'b0;
            if (glitch && k == 4) dyn_event = 1'b1;
            tick();                    // edge T+k
            if (dyn_energy_valid) begin
                strobes++;
                strobe_at = k;
                energy    = dyn_energy;
                pu_o      = dyn_energy_pu;
            end
        end
        dyn_pileup = 1'b0;
        busy_hold  = dyn_busy;
        dyn_event  = 1'b0;
        tick();
        busy_end   = dyn_busy;
        tick();
    endtask

    int          st, sat;
    logic [15:0] en;
    logic        puo, bh, be;

    initial begin
        reset_n    = 1'b0;
        dyn_event  = 1'b0;
        dyn_pileup = 1'b0;
        dyn_adcdly = 8'd0;
        dyn_curval = 16'd0;
        intlen     = 6'd0;
        tick();
        tick();
        check("rst_energy", dyn_energy, 0);
        check("rst_valid", dyn_energy_valid, 0);
        check("rst_busy", dyn_busy, 0);
        check("rst_evcnt", dyn_evcnt, 0);
        reset_n = 1'b1;
        tick();

        // 16 samples of 30 over a baseline of 20: 16*10*256/64 = 640
        run_event(16'h1400, 6'd16, 8'd20, 8'd30, 0, 1'b0, st, sat, en, puo, bh, be);
        check("t1_strobes", st, 1);
        check("t1_strobe_at", sat, 17);
        check("t1_energy", en, 640);
        check("t1_pu", puo, 0);
        check("t1_evcnt", dyn_evcnt, 1);
        check("t1_busy_hold", bh, 1);
        check("t1_busy_end", be, 0);
        check("t1_energy_held", dyn_energy, 640);

        // Samples below baseline clamp to zero
        run_event(16'h1400, 6'd8, 8'd10, 8'd10, 0, 1'b0, st, sat, en, puo, bh, be);
        check("t2_strobes", st, 1);
        check("t2_strobe_at", sat, 9);
        check("t2_energy", en, 0);
        check("t2_evcnt", dyn_evcnt, 2);

        // intlen=0 means 64 samples at full scale: 64*255*256/64 = 0xFF00
        run_event(16'h0000, 6'd0, 8'd255, 8'd255, 0, 1'b0, st, sat, en, puo, bh, be);
        check("t3_strobes", st, 1);
        check("t3_strobe_at", sat, 65);
        check("t3_energy", en, 16'hFF00);
        check("t3_evcnt", dyn_evcnt, 3);

        // Pileup at T+5 of a 16-sample window
        run_event(16'h1400, 6'd16, 8'd20, 8'd30, 5, 1'b0, st, sat, en, puo, bh, be);
`ifdef DYN_EINT_PUABORT_EN
        check("t4_strobes", st, 0);
        check("t4_energy_kept", dyn_energy, 16'hFF00);
        check("t4_pu_out", dyn_energy_pu, 0);
`else
        check("t4_strobes", st, 1);
        check("t4_strobe_at", sat, 17);
        check("t4_energy", en, 640);
        check("t4_pu", puo, 1);
`endif
        check("t4_evcnt_sat", dyn_evcnt, 3);
        check("t4_busy_hold", bh, 1);
        check("t4_busy_end", be, 0);

        // Second rising edge during INTEG is ignored; held event keeps HOLDOFF
        run_event(16'h1400, 6'd4, 8'd20, 8'd25, 0, 1'b1, st, sat, en, puo, bh, be);
        check("t5_strobes", st, 1);
        check("t5_strobe_at", sat, 5);
        check("t5_energy", en, 80);
        check("t5_pu", puo, 0);
        check("t5_busy_hold", bh, 1);
        check("t5_busy_end", be, 0);
        check("t5_evcnt_sat", dyn_evcnt, 3);

        // Reset at T+8 of a 16-sample event
        dyn_curval = 16'h1400;
        intlen     = 6'd16;
        dyn_adcdly = 8'd30;
        dyn_event  = 1'b1;
        tick();                        // edge T
        for (int k = 1; k < 8; k++) tick();
        reset_n   = 1'b0;
        dyn_event = 1'b0;
        tick();                        // edge T+8
        check("t6_energy", dyn_energy, 0);
        check("t6_valid", dyn_energy_valid, 0);
        check("t6_pu", dyn_energy_pu, 0);
        check("t6_busy", dyn_busy, 0);
        check("t6_evcnt", dyn_evcnt, 0);
        reset_n = 1'b1;
        st = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dyn_energy_valid) st++;
        end
        check("t6_no_strobe", st, 0);

        run_event(16'h1400, 6'd16, 8'd20, 8'd30, 0, 1'b0, st, sat, en, puo, bh, be);
        check("t7_strobes", st, 1);
        check("t7_strobe_at", sat, 17);
        check("t7_energy", en, 640);
        check("t7_evcnt", dyn_evcnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dynode_energy_int.md
# dynode_energy_int

Baseline-corrected energy integrator for one dynode channel. It sits directly downstream of the dynode baseline stage and consumes the delayed ADC stream (`dyn_adcdly`) and the 8.8 fixed-point baseline (`dyn_curval`). On each detected event it integrates a programmable number of samples, subtracts the baseline latched at event start, and presents a clamped energy word with a one-cycle valid strobe, a pileup flag and a running event count.

## Interface
- `CNTW`, default 16: width of the completed-event counter.

- `clk` in 1: system clock, all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `dyn_event` in 1: event detected, level; integration starts on its rising edge.
- `dyn_pileup` in 1: pileup detected, level.
- `dyn_adcdly` in 8: delayed dynode ADC sample, unsigned.
- `dyn_curval` in 16: baseline, 8.8 fixed point, so `dyn_curval/256` = baseline per sample in ADC LSB.
- `intlen` in 6: samples to integrate; 1..63 literal, 0 means 64.
- `dyn_energy` out 16: energy, unsigned, LSB = 1/4 ADC count.
- `dyn_energy_valid` out 1: one-cycle strobe when `dyn_energy` is updated.
- `dyn_energy_pu` out 1: pileup seen during the window; qualified by valid.
- `dyn_busy` out 1: high in any state other than IDLE.
- `dyn_evcnt` out CNTW: count of valid strobes, saturating at all-ones.

## Operation
- States:
  - IDLE: wait for an event start.
  - INTEG: accumulate samples.
  - DONE: publish the result.
  - HOLDOFF: wait for `dyn_event` to return low.
- `event_d` is the registered copy of `dyn_event`. Rising edge = `dyn_event & !event_d`.
- IDLE → INTEG on a rising edge. On that same edge:
  - `bl` ← `dyn_curval`
  - `cnt` ← `intlen` (0 loads 64)
  - `acc` ← 0
  - `pu` ← 0
- INTEG, every edge:
  - `acc` ← `acc` + ({`dyn_adcdly`, 8'h00} − `bl`). The difference is signed 17 bits; `acc` is signed 24 bits.
  - `cnt` decrements.
  - `pu` ← `pu | dyn_pileup`.
  - When `cnt`==1 on that edge → DONE.
- DONE, one edge:
  - `dyn_energy` ← 0 if `acc`<0, else `acc[21:6]`.
  - `dyn_energy_pu` ← `pu`; `dyn_energy_valid` ← 1.
  - `dyn_evcnt` increments unless already saturated.
  - Next state: HOLDOFF.
- HOLDOFF → IDLE when `dyn_event`==0, sampled on the edge. If `dyn_event` is already low at DONE, HOLDOFF lasts one cycle.
- The maximum positive `acc` is 64·255·256 = 4177920 < 2^22, so no upper saturation is needed.
- Rising edges of `dyn_event` outside IDLE are ignored. No queuing.
- `intlen` and `dyn_curval` changes after the start edge have no effect on the event in progress.
- `dyn_energy` and `dyn_energy_pu` hold their values between strobes.
- Reset (`reset_n`=0 on an edge), from any state including mid-INTEG:
  - state ← IDLE
  - `dyn_energy`, `dyn_energy_valid`, `dyn_energy_pu`, `dyn_evcnt`, `acc`, `cnt`, `bl`, `pu`, `event_d` ← 0
  - `dyn_busy` = 0
  - An event in progress is discarded without a strobe.

## Timing
- Start edge = T, the edge where `dyn_event`=1 and `event_d`=0.
- Samples integrated are the `dyn_adcdly` values present at edges T+1 … T+N.
- DONE executes at edge T+N+1. `dyn_energy_valid` is high for exactly the cycle following edge T+N+1.
- `dyn_busy` is high from after edge T until the HOLDOFF→IDLE edge.
- `dyn_pileup` counts only if it is high at an edge T+1 … T+N.
- Earliest next start is the edge after returning to IDLE. `dyn_event` must be observed low, then high.

## Configuration
- `DYN_EINT_PUABORT_EN`
  - Defined: `dyn_pileup`=1 at any INTEG edge aborts the event. State goes to HOLDOFF, no strobe, `dyn_energy` and `dyn_evcnt` are unchanged, and `dyn_energy_pu` is never asserted.
  - Undefined: integration always completes and pileup is reported via `dyn_energy_pu`.

## Test plan
- `dyn_curval`=16'h1400, `intlen`=16, ADC 20 idle then 30 for 16 samples after the start edge → one strobe at T+17 cycle, `dyn_energy`=640, pu=0, `dyn_evcnt`=1.
- `dyn_curval`=16'h1400, ADC 10 throughout an event → `dyn_energy`=0 (negative clamp), strobe asserted.
- `intlen`=0, `dyn_curval`=0, ADC 255 → 64 samples integrated, `dyn_energy`=16'hFF00, strobe at T+65.
- `dyn_pileup` pulsed at T+5, `intlen`=16:
  - Macro undefined: strobe with `dyn_energy_pu`=1.
  - Macro defined: no strobe, `dyn_evcnt` unchanged, `dyn_busy` falls after `dyn_event` goes low.
- `reset_n`=0 at T+8 of a 16-sample event → all outputs 0 next cycle, no strobe. A new rising edge after reset produces a correct result.
- `dyn_event` held high across DONE, with a second rising edge attempted during INTEG → one strobe only. IDLE is re-entered only after `dyn_event` goes low.
